elevator_shaft_model: RTL and testbench
=======================================

ELEVATOR_SHAFT_MODEL -- requirements
Module: elevator_shaft_model

Interface
REQ-001 SHALL have parameter FLOOR_COUNT, default 10, number of floors (floor indices 0..FLOOR_COUNT-1).
REQ-002 SHALL have parameter TICKS_PER_FLOOR, default 8, clock cycles to travel one floor (minimum 2).
REQ-003 SHALL have parameter DOOR_TICKS, default 4, clock cycles for a full door open or close stroke (minimum 1).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port motor_up  input  1  controller command: drive cabin upward.
REQ-007 SHALL have port motor_down  input  1  controller command: drive cabin downward.
REQ-008 SHALL have port door  input  1  controller command: 1 = open door, 0 = close door.
REQ-009 SHALL have port position  output  32  current floor index, unsigned, registered.
REQ-010 SHALL have port at_floor  output  1  cabin level with a floor, i.e. not travelling.
REQ-011 SHALL have port moving  output  1  cabin travelling.
REQ-012 SHALL have port arrive  output  1  one-cycle pulse when the cabin reaches a new floor.
REQ-013 SHALL have port door_open  output  1  door fully open.
REQ-014 SHALL have port fault  output  1  sticky unsafe-command indication.

Function
REQ-015 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING, FAULT; all outputs registered and decoded from state, position and arrive.
REQ-016 SHALL, in IDLE: motor_up and motor_down both 1 -> FAULT; door=1 with either motor bit 1 -> FAULT; door=1 alone -> DOOR_OPENING; motor_up alone -> MOVE_UP if position < FLOOR_COUNT-1, otherwise stay IDLE; motor_down alone -> MOVE_DOWN if position > 0, otherwise stay IDLE.
REQ-017 SHALL keep a travel counter, cleared on entry to MOVE_UP/MOVE_DOWN and incremented every cycle in those states; position changes by exactly +1/-1, with arrive=1 for that one cycle, TICKS_PER_FLOOR cycles after the state becomes MOVE_*.
REQ-018 SHALL, at each floor boundary in MOVE_UP, clear the counter and stay in MOVE_UP if motor_up=1 and the new position < FLOOR_COUNT-1, otherwise go to IDLE; MOVE_DOWN is symmetric with motor_down and position > 0.
REQ-019 SHALL finish travel to the next floor if the motor command drops mid-floor; the cabin never stops between floors.
REQ-020 SHALL enter FAULT from MOVE_UP on motor_down=1, from MOVE_DOWN on motor_up=1, and from any MOVE_* state on door=1.
REQ-021 SHALL, in DOOR_OPENING, count DOOR_TICKS cycles and then enter DOOR_OPEN; if door drops to 0 during opening, go directly to DOOR_CLOSING with a full DOOR_TICKS stroke.
REQ-022 SHALL hold DOOR_OPEN while door=1; door=0 -> DOOR_CLOSING; after DOOR_TICKS cycles go to IDLE; door=1 during closing -> DOOR_OPENING with a full stroke.
REQ-023 SHALL enter FAULT if motor_up or motor_down is 1 in any door state; the FAULT check takes priority over all other transitions in the same cycle.
REQ-024 SHALL make FAULT absorbing until reset: fault=1, moving=0, door_open=0, at_floor=1, position frozen, arrive=0.
REQ-025 SHALL drive moving=1 only in MOVE_UP/MOVE_DOWN, at_floor=~moving, and door_open=1 only in DOOR_OPEN.
REQ-026 SHALL never let position leave 0..FLOOR_COUNT-1; no wrap-around.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, set state=IDLE, position=0, counters=0, moving=0, arrive=0, door_open=0, fault=0, at_floor=1, overriding all other inputs including FAULT and mid-travel.
REQ-028 SHALL sample commands on the first rising edge with reset=1.

Verification
REQ-029 Reset, then motor_up=1 held -> moving=1 one cycle later; position 1 at 8 cycles, 2 at 16 cycles, ... 9 at 72 cycles after MOVE_UP entry, one arrive pulse per floor, then IDLE at floor 9 although motor_up is still 1.
REQ-030 At floor 3, pulse motor_down=1 for 1 cycle -> position=2 exactly 8 cycles after MOVE_DOWN entry, single arrive pulse, then IDLE.
REQ-031 In IDLE, door=1 -> door_open=1 after 4 cycles in DOOR_OPENING; door=0 -> door_open=0 next cycle, IDLE after 4 cycles; re-assert door during closing -> full 4-cycle reopen.
REQ-032 During MOVE_UP assert door=1 -> fault=1 and moving=0 next cycle; position frozen; further commands ignored; reset=0 -> position=0, fault=0.
REQ-033 IDLE at floor 0: motor_down=1 -> stays IDLE, position=0; motor_up=1 and motor_down=1 together -> FAULT.
REQ-034 Assert reset=0 mid-travel at counter 5 -> next edge position=0, moving=0, arrive=0, no residual arrive pulse after release.

Source files
------------

// File: rtl/elevator_shaft_model.sv
// ---------------------------------------------------------------------------
// elevator_shaft_model
//   Cycle-accurate behavioural model of a single elevator shaft: cabin
//   travel between floors, door stroke timing and unsafe-command detection.
//   A controller drives the motor/door commands; the model reports the
//   cabin position and status flags. All outputs come straight from
//   registers (state, position, arrive).
//
// Parameters
//   FLOOR_COUNT     number of floors, indices 0..FLOOR_COUNT-1
//   TICKS_PER_FLOOR cycles to travel one floor (>= 2)
//   DOOR_TICKS      cycles for one full door open or close stroke (>= 1)
//
// Ports
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-low
//   motor_up    in   command: drive cabin up
//   motor_down  in   command: drive cabin down
//   door        in   command: 1 = open door, 0 = close door
//   position    out  current floor index (32-bit unsigned)
//   at_floor    out  cabin level with a floor (not travelling)
//   moving      out  cabin travelling
//   arrive      out  one-cycle pulse when a new floor is reached
//   door_open   out  door fully open
//   fault       out  sticky unsafe-command flag, cleared only by reset
//
// State table
//   ST_IDLE         | parked at a floor, door closed, awaiting command
//   ST_MOVE_UP      | travelling up, counter runs toward next floor
//   ST_MOVE_DOWN    | travelling down, counter runs toward next floor
//   ST_DOOR_OPENING | door stroke opening, counter runs to DOOR_TICKS
//   ST_DOOR_OPEN    | door fully open, held while door=1
//   ST_DOOR_CLOSING | door stroke closing, counter runs to DOOR_TICKS
//   ST_FAULT        | unsafe command seen; frozen until reset
// ---------------------------------------------------------------------------
module elevator_shaft_model #(
  parameter int FLOOR_COUNT     = 10,
  parameter int TICKS_PER_FLOOR = 8,
  parameter int DOOR_TICKS      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        motor_up,
  input  logic        motor_down,
  input  logic        door,
  output logic [31:0] position,
  output logic        at_floor,
  output logic        moving,
  output logic        arrive,
  output logic        door_open,
  output logic        fault
);

  localparam int MAX_TICKS = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  // Terminal-count values: the counter is cleared on state entry, so the
  // transition happens on the edge where it already holds N-1, i.e. N cycles
  // after entry.
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TICKS_PER_FLOOR - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [31:0]      TOP_FLOOR   = 32'(FLOOR_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_MOVE_UP      = 3'd1,
    ST_MOVE_DOWN    = 3'd2,
    ST_DOOR_OPENING = 3'd3,
    ST_DOOR_OPEN    = 3'd4,
    ST_DOOR_CLOSING = 3'd5,
    ST_FAULT        = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pos_q, pos_d;
  logic             arrive_q, arrive_d;

  logic             cmd_both;
  logic             cmd_any_motor;
  logic [31:0]      pos_inc;
  logic [31:0]      pos_dec;
  logic             travel_done;
  logic             door_done;

  assign cmd_both      = motor_up & motor_down;
  assign cmd_any_motor = motor_up | motor_down;
  assign pos_inc       = pos_q + 32'd1;
  assign pos_dec       = pos_q - 32'd1;
  assign travel_done   = (cnt_q == TRAVEL_LAST);
  assign door_done     = (cnt_q == DOOR_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    arrive_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_both || (door && cmd_any_motor)) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_ZERO;
        end else if (door) begin
          state_d = ST_DOOR_OPENING;
          cnt_d   = CNT_ZERO;
        end else if (motor_up && (pos_q < TOP_FLOOR)) begin
          state_d = ST_MOVE_UP;
          cnt_d   = CNT_ZERO;
        end else if (motor_down && (pos_q != 32'd0)) begin
          state_d = ST_MOVE_DOWN;
          cnt_d   = CNT_ZERO;
        end
      end

      // The fault check comes first so an unsafe command on the arrival
      // edge freezes the cabin without a position step or arrive pulse.
      // Motor release mid-floor is ignored: direction is only re-evaluated
      // at the floor boundary.
      ST_MOVE_UP: begin
        if (motor_down || door) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_ZERO;
        end else if (travel_done) begin
          pos_d    = pos_inc;
          arrive_d = 1'b1;
          cnt_d    = CNT_ZERO;
          if (!(motor_up && (pos_inc < TOP_FLOOR))) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_MOVE_DOWN: begin
        if (motor_up || door) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_ZERO;
        end else if (travel_done) begin
          pos_d    = pos_dec;
          arrive_d = 1'b1;
          cnt_d    = CNT_ZERO;
          if (!(motor_down && (pos_dec != 32'd0))) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A door reversal restarts a full stroke in the other direction;
      // the reversal wins over stroke completion on the same edge.
      ST_DOOR_OPENING: begin
        if (cmd_any_motor) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_ZERO;
        end else if (!door) begin
          state_d = ST_DOOR_CLOSING;
          cnt_d   = CNT_ZERO;
        end else if (door_done) begin
          state_d = ST_DOOR_OPEN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DOOR_OPEN: begin
        if (cmd_any_motor) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_ZERO;
        end else if (!door) begin
          state_d = ST_DOOR_CLOSING;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_DOOR_CLOSING: begin
        if (cmd_any_motor) begin
          state_d = ST_FAULT;
          cnt_d   = CNT_ZERO;
        end else if (door) begin
          state_d = ST_DOOR_OPENING;
          cnt_d   = CNT_ZERO;
        end else if (door_done) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      // Unused encoding: treat as unsafe.
      default: begin
        state_d = ST_FAULT;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      pos_q    <= 32'd0;
      arrive_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      arrive_q <= arrive_d;
    end
  end

  assign position  = pos_q;
  assign moving    = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);
  assign at_floor  = ~moving;
  assign arrive    = arrive_q;
  assign door_open = (state_q == ST_DOOR_OPEN);
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_elevator_shaft_model.sv
module tb_elevator_shaft_model;

  localparam int FC  = 10;
  localparam int TPF = 8;
  localparam int DT  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        motor_up = 1'b0;
  logic        motor_down = 1'b0;
  logic        door = 1'b0;
  logic [31:0] position;
  logic        at_floor, moving, arrive, door_open, fault;

  int tests = 0;
  int fails = 0;

  elevator_shaft_model #(
    .FLOOR_COUNT(FC), .TICKS_PER_FLOOR(TPF), .DOOR_TICKS(DT)
  ) dut (
    .clock(clock), .reset(reset), .motor_up(motor_up), .motor_down(motor_down),
    .door(door), .position(position), .at_floor(at_floor), .moving(moving),
    .arrive(arrive), .door_open(door_open), .fault(fault)
  );

  always #5 clock = ~clock;

  // Reference model: a mode name plus "cycles left until the next event".
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_OPENING = 3,
                 M_OPEN = 4, M_CLOSING = 5, M_FAULT = 6;
  int m_mode = M_IDLE;
  int m_pos  = 0;
  int m_left = 0;
  bit m_arr  = 1'b0;

  task model_step();
    bit u, d, o;
    u = motor_up; d = motor_down; o = door;
    m_arr = 1'b0;
    if (!reset) begin
      m_mode = M_IDLE; m_pos = 0; m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE:
          if ((u && d) || (o && (u || d))) m_mode = M_FAULT;
          else if (o) begin m_mode = M_OPENING; m_left = DT; end
          else if (u && m_pos < FC - 1) begin m_mode = M_UP; m_left = TPF; end
          else if (d && m_pos > 0) begin m_mode = M_DOWN; m_left = TPF; end
        M_UP:
          if (d || o) m_mode = M_FAULT;
          else begin
            m_left--;
            if (m_left == 0) begin
              m_pos++; m_arr = 1'b1;
              if (u && m_pos < FC - 1) m_left = TPF; else m_mode = M_IDLE;
            end
          end
        M_DOWN:
          if (u || o) m_mode = M_FAULT;
          else begin
            m_left--;
            if (m_left == 0) begin
              m_pos--; m_arr = 1'b1;
              if (d && m_pos > 0) m_left = TPF; else m_mode = M_IDLE;
            end
          end
        M_OPENING:
          if (u || d) m_mode = M_FAULT;
          else if (!o) begin m_mode = M_CLOSING; m_left = DT; end
          else begin m_left--; if (m_left == 0) m_mode = M_OPEN; end
        M_OPEN:
          if (u || d) m_mode = M_FAULT;
          else if (!o) begin m_mode = M_CLOSING; m_left = DT; end
        M_CLOSING:
          if (u || d) m_mode = M_FAULT;
          else if (o) begin m_mode = M_OPENING; m_left = DT; end
          else begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
        default: m_mode = M_FAULT;
      endcase
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return {27'd0, position, at_floor, moving, arrive, door_open, fault};
  endfunction

  function automatic logic [63:0] pack_exp(input logic [31:0] p, input logic mv,
                                           input logic ar, input logic dop, input logic fl);
    return {27'd0, p, ~mv, mv, ar, dop, fl};
  endfunction

  task automatic set_in(input logic r, input logic u, input logic d, input logic o);
    reset = r; motor_up = u; motor_down = d; door = o;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        rst, up, dn, dr;
    int          n;
    logic [31:0] pos;
    logic        mov, arr, dop, flt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int arr_cnt;
    logic [63:0] exp_v;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 7, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      set_in(vecs[i].rst, vecs[i].up, vecs[i].dn, vecs[i].dr);
      for (int k = 0; k < vecs[i].n; k++) cycle();
      chk($sformatf("vec%0d", i), pack_out(),
          pack_exp(vecs[i].pos, vecs[i].mov, vecs[i].arr, vecs[i].dop, vecs[i].flt));
    end

    // ---- full climb to the top floor with motor_up held ----
    do_reset();
    chk("reset_state", pack_out(), pack_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    motor_up = 1'b1;
    arr_cnt = 0;
    for (int e = 0; e <= 80; e++) begin
      int ep;
      cycle();
      ep = (e / TPF > FC - 1) ? FC - 1 : e / TPF;
      if (arrive) arr_cnt++;
      chk($sformatf("climb_e%0d", e), pack_out(),
          pack_exp(32'(ep), (e < (FC - 1) * TPF), (e > 0 && e % TPF == 0 && e <= (FC - 1) * TPF),
                   1'b0, 1'b0));
    end
    chk("climb_arrive_count", 64'(arr_cnt), 64'(FC - 1));

    // ---- single-floor descent from floor 3 on a one-cycle pulse ----
    do_reset();
    motor_up = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    motor_up = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    chk("at_floor3", pack_out(), pack_exp(32'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    motor_down = 1'b1;
    cycle();
    motor_down = 1'b0;
    chk("down_entry", pack_out(), pack_exp(32'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    arr_cnt = 0;
    for (int k = 1; k <= TPF + 3; k++) begin
      cycle();
      if (arrive) arr_cnt++;
      chk($sformatf("down_k%0d", k), pack_out(),
          pack_exp((k < TPF) ? 32'd3 : 32'd2, (k < TPF), (k == TPF), 1'b0, 1'b0));
    end
    chk("down_arrive_count", 64'(arr_cnt), 64'd1);

    // ---- door reopen during closing ----
    do_reset();
    door = 1'b1;
    for (int k = 0; k < DT + 1; k++) cycle();
    chk("door_opened", pack_out(), pack_exp(32'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    door = 1'b0;
    cycle();
    chk("door_close_start", pack_out(), pack_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle(); cycle();
    door = 1'b1;
    for (int k = 0; k <= DT; k++) begin
      cycle();
      chk($sformatf("reopen_k%0d", k), pack_out(),
          pack_exp(32'd0, 1'b0, 1'b0, (k == DT), 1'b0));
    end

    // ---- door command during travel -> frozen fault ----
    do_reset();
    motor_up = 1'b1;
    for (int k = 0; k < TPF + 2; k++) cycle();
    door = 1'b1;
    cycle();
    chk("fault_entry", pack_out(), pack_exp(32'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle();
      chk($sformatf("fault_hold%0d", k), pack_out(), pack_exp(32'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("fault_reset", pack_out(), pack_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // ---- reset mid-travel at counter value 5 ----
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < TPF + 6; k++) cycle();
    chk("pre_reset_travel", pack_out(), pack_exp(32'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    cycle();
    chk("midtravel_reset", pack_out(), pack_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk($sformatf("post_reset%0d", k), pack_out(), pack_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // ---- randomized run against the reference model ----
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int r;
        r = $urandom_range(0, 15);
        motor_up   = (r >= 4 && r <= 6) || r == 14 || r == 15;
        motor_down = (r >= 7 && r <= 9) || r == 14;
        door       = (r >= 10 && r <= 13) || r == 15;
      end
      reset = !((m_mode == M_FAULT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 149) == 0));
      cycle();
      exp_v = pack_exp(32'(m_pos), (m_mode == M_UP || m_mode == M_DOWN), m_arr,
                       (m_mode == M_OPEN), (m_mode == M_FAULT));
      chk($sformatf("rand%0d", c), pack_out(), exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
